// File: rtl/ring_flasher_param_if.sv
// Control and status bundle for the ring sequencer.
// The master side (button/timer logic) drives start, stop and dir.
// The slave side (the sequencer) returns the LED drive and run status.
interface ring_flasher_param_if #(
  parameter int N_LEDS = 16
);
  logic              start;
  logic              stop;
  logic              dir;
  logic [N_LEDS-1:0] led;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [2:0]        phase;

  modport master (
    output start, stop, dir,
    input  led, busy, done, timeout, phase
  );

  modport slave (
    input  start, stop, dir,
    output led, busy, done, timeout, phase
  );
endinterface

// File: rtl/ring_flasher_param.sv
// Parametrised ring LED sequencer.
// A fill phase lays a segment forward and erases part of it backward.
// A toggle phase then XORs the segment forward and backward until the ring
// is dark or the toggle-round limit is reached.
// Every step except the IDLE->FWD launch waits for a prescaler tick.
module ring_flasher_param #(
  parameter int N_LEDS            = 16,
  parameter int SEG_LEN           = 8,
  parameter int BACK_LEN          = 4,
  parameter int FILL_CYCLES       = 3,
  parameter int MAX_TOGGLE_ROUNDS = 8,
  parameter int TICK_DIV          = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  ring_flasher_param_if.slave  bus
);

  localparam int PTR_W  = $clog2(N_LEDS);
  localparam int CNT_W  = $clog2(SEG_LEN + 1);
  localparam int RMAX   = (FILL_CYCLES > MAX_TOGGLE_ROUNDS) ? FILL_CYCLES : MAX_TOGGLE_ROUNDS;
  localparam int RND_W  = $clog2(RMAX + 1);
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(N_LEDS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FWD   = 3'd1,
    BWD   = 3'd2,
    TFWD  = 3'd3,
    TBWD  = 3'd4,
    CHECK = 3'd5
  } state_t;

  state_t            state_q, state_n;
  logic [PTR_W-1:0]  ptr_q, ptr_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [RND_W-1:0]  rounds_q, rounds_n;
  logic [PRE_W-1:0]  pre_q, pre_n;
  logic [N_LEDS-1:0] led_q, led_n;
  logic              dir_q, dir_n;
  logic              busy_q;
  logic              done_q, done_n;
  logic              timeout_q, timeout_n;

  logic              tick;
  logic [PTR_W-1:0]  ptr_up, ptr_down, ptr_plus, ptr_minus;

  assign tick = (pre_q == PRE_W'(TICK_DIV - 1));

  // Ring neighbours use an explicit compare so non-power-of-2 rings wrap correctly.
  assign ptr_up    = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
  assign ptr_down  = (ptr_q == '0) ? LAST : ptr_q - 1'b1;
  assign ptr_plus  = dir_q ? ptr_down : ptr_up;
  assign ptr_minus = dir_q ? ptr_up : ptr_down;

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      rounds_q  <= '0;
      pre_q     <= '0;
      led_q     <= '0;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      ptr_q     <= ptr_n;
      cnt_q     <= cnt_n;
      rounds_q  <= rounds_n;
      pre_q     <= pre_n;
      led_q     <= led_n;
      dir_q     <= dir_n;
      busy_q    <= (state_n != IDLE);
      done_q    <= done_n;
      timeout_q <= timeout_n;
    end
  end

  // Next-state and next-datapath decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_n   = state_q;
    ptr_n     = ptr_q;
    cnt_n     = cnt_q;
    rounds_n  = rounds_q;
    pre_n     = '0;
    led_n     = led_q;
    dir_n     = dir_q;
    done_n    = 1'b0;
    timeout_n = timeout_q;

    if (state_q == IDLE) begin
      led_n = '0;
      if (bus.start && !bus.stop) begin
        dir_n     = bus.dir;
        ptr_n     = bus.dir ? LAST : '0;
        cnt_n     = '0;
        rounds_n  = '0;
        timeout_n = 1'b0;
        state_n   = FWD;
      end
    end else if (bus.stop) begin
      led_n   = '0;
      state_n = IDLE;
    end else begin
      pre_n = tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        case (state_q)
          FWD, TFWD: begin
            if (32'(cnt_q) < SEG_LEN) begin
              led_n[ptr_q] = (state_q == FWD) ? 1'b1 : ~led_q[ptr_q];
              ptr_n        = ptr_plus;
              cnt_n        = cnt_q + 1'b1;
            end else begin
              ptr_n   = ptr_minus;
              cnt_n   = CNT_W'(BACK_LEN);
              state_n = (state_q == FWD) ? BWD : TBWD;
            end
          end
          BWD, TBWD: begin
            if (cnt_q != '0) begin
              led_n[ptr_q] = (state_q == BWD) ? 1'b0 : ~led_q[ptr_q];
              ptr_n        = ptr_minus;
              cnt_n        = cnt_q - 1'b1;
            end else begin
              ptr_n = ptr_plus;
              cnt_n = '0;
              if (state_q == TBWD) begin
                rounds_n = rounds_q + 1'b1;
                state_n  = CHECK;
              end else if ((32'(rounds_q) + 1) < FILL_CYCLES) begin
                rounds_n = rounds_q + 1'b1;
                state_n  = FWD;
              end else begin
                rounds_n = '0;
                state_n  = TFWD;
              end
            end
          end
          CHECK: begin
            if (led_q == '0) begin
              done_n  = 1'b1;
              state_n = IDLE;
            end else if (32'(rounds_q) == MAX_TOGGLE_ROUNDS) begin
              led_n     = '0;
              timeout_n = 1'b1;
              done_n    = 1'b1;
              state_n   = IDLE;
            end else begin
              state_n = TFWD;
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end

    if (state_n == IDLE) pre_n = '0;
  end

  assign bus.led     = led_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.timeout = timeout_q;
  assign bus.phase   = state_q;

endmodule

// File: tb/tb_ring_flasher_param.sv
// Directed bench for ring_flasher_param: default ring, prescaled ring,
// short toggle limit and a 10-LED wrap-around ring run side by side.
module tb_ring_flasher_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ring_flasher_param_if #(.N_LEDS(16)) bus_def  ();
  ring_flasher_param_if #(.N_LEDS(16)) bus_div  ();
  ring_flasher_param_if #(.N_LEDS(16)) bus_to   ();
  ring_flasher_param_if #(.N_LEDS(10)) bus_wrap ();

  ring_flasher_param u_def (.clk(clk), .rst(rst), .bus(bus_def));
  ring_flasher_param #(.TICK_DIV(4)) u_div (.clk(clk), .rst(rst), .bus(bus_div));
  ring_flasher_param #(.MAX_TOGGLE_ROUNDS(3)) u_to (.clk(clk), .rst(rst), .bus(bus_to));
  ring_flasher_param #(.N_LEDS(10), .SEG_LEN(6), .BACK_LEN(2), .FILL_CYCLES(3))
    u_wrap (.clk(clk), .rst(rst), .bus(bus_wrap));

  // The 10-LED ring pointer must never leave 0..9.
  always @(negedge clk) begin
    if (!rst && u_wrap.ptr_q > 4'd9) begin
      errors++;
      $display("FAIL wrap_ptr_range got %0d want <=9", u_wrap.ptr_q);
    end
  end

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  // Advance to the given edge (start edge = 1) and sample 1 time unit later.
  task automatic step_to(inout int e, input int target);
    while (e < target) begin
      @(posedge clk);
      e++;
    end
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_led",     64'(bus_def.led),     64'h0);
    chk("reset_busy",    64'(bus_def.busy),    64'h0);
    chk("reset_phase",   64'(bus_def.phase),   64'h0);
    chk("reset_done",    64'(bus_def.done),    64'h0);
    chk("reset_timeout", 64'(bus_def.timeout), 64'h0);
  endtask

  task automatic run_default(input logic d);
    int          e;
    int          edges [9] = '{9, 15, 29, 43, 57, 72, 87, 102, 117};
    logic [15:0] vals  [9] = '{16'h00FF, 16'h000F, 16'h00FF, 16'h0FFF,
                               16'hFFFF, 16'hFFF0, 16'hFF00, 16'hF000, 16'h0000};
    logic [15:0] want;
    bus_def.dir   = d;
    bus_def.start = 1'b1;
    @(posedge clk);
    e = 1;
    #1;
    bus_def.start = 1'b0;
    chk("run_phase_fwd", 64'(bus_def.phase), 64'd1);
    for (int i = 0; i < 9; i++) begin
      step_to(e, edges[i]);
      want = d ? rev16(vals[i]) : vals[i];
      checks++;
      if (bus_def.led !== want) begin
        errors++;
        $display("FAIL run_dir%0d_led_edge%0d got %h want %h", d, edges[i], bus_def.led, want);
      end
    end
    chk("run_done_early", 64'(bus_def.done), 64'h0);
    step_to(e, 118);
    chk("run_done",       64'(bus_def.done),    64'h1);
    chk("run_busy_after", 64'(bus_def.busy),    64'h0);
    chk("run_led_after",  64'(bus_def.led),     64'h0);
    chk("run_timeout",    64'(bus_def.timeout), 64'h0);
    step_to(e, 119);
    chk("run_done_pulse", 64'(bus_def.done),    64'h0);
  endtask

  task automatic test_fill_toggle();
    run_default(1'b0);
  endtask

  task automatic test_dir_reverse();
    run_default(1'b1);
  endtask

  task automatic test_reset_mid_run();
    int e;
    bus_def.dir   = 1'b0;
    bus_def.start = 1'b1;
    @(posedge clk);
    e = 1;
    #1;
    bus_def.start = 1'b0;
    step_to(e, 46);
    chk("midrst_in_tfwd", 64'(bus_def.phase), 64'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_led",     64'(bus_def.led),     64'h0);
    chk("midrst_busy",    64'(bus_def.busy),    64'h0);
    chk("midrst_phase",   64'(bus_def.phase),   64'h0);
    chk("midrst_done",    64'(bus_def.done),    64'h0);
    chk("midrst_timeout", 64'(bus_def.timeout), 64'h0);
  endtask

  task automatic test_abort();
    int e;
    bus_def.dir   = 1'b0;
    bus_def.start = 1'b1;
    @(posedge clk);
    e = 1;
    #1;
    bus_def.start = 1'b0;
    step_to(e, 26);
    chk("abort_in_bwd", 64'(bus_def.phase), 64'd2);
    bus_def.stop = 1'b1;
    step_to(e, 27);
    bus_def.stop = 1'b0;
    chk("abort_led",   64'(bus_def.led),   64'h0);
    chk("abort_phase", 64'(bus_def.phase), 64'h0);
    chk("abort_busy",  64'(bus_def.busy),  64'h0);
    for (int i = 0; i < 5; i++) begin
      chk("abort_no_done", 64'(bus_def.done), 64'h0);
      step_to(e, e + 1);
    end
  endtask

  task automatic test_start_held();
    int e;
    bus_def.dir   = 1'b0;
    bus_def.start = 1'b1;
    @(posedge clk);
    e = 1;
    #1;
    step_to(e, 10);
    bus_def.dir = 1'b1;
    step_to(e, 15);
    chk("held_round1", 64'(bus_def.led), 64'h000F);
    step_to(e, 29);
    chk("held_round2", 64'(bus_def.led), 64'h00FF);
    step_to(e, 118);
    chk("held_done",   64'(bus_def.done), 64'h1);
    step_to(e, 119);
    chk("held_restart_phase", 64'(bus_def.phase), 64'd1);
    chk("held_restart_led",   64'(bus_def.led),   64'h0);
    step_to(e, 120);
    chk("held_restart_dir1",  64'(bus_def.led),   64'h8000);
    bus_def.start = 1'b0;
    bus_def.stop  = 1'b1;
    step_to(e, 121);
    bus_def.stop  = 1'b0;
    chk("held_stopped", 64'(bus_def.phase), 64'd0);
  endtask

  task automatic test_start_stop_idle();
    int e = 0;
    bus_def.start = 1'b1;
    bus_def.stop  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_to(e, e + 1);
      chk("startstop_phase", 64'(bus_def.phase), 64'd0);
      chk("startstop_busy",  64'(bus_def.busy),  64'h0);
    end
    bus_def.start = 1'b0;
    bus_def.stop  = 1'b0;
  endtask

  task automatic test_timeout();
    int e;
    bus_to.dir   = 1'b0;
    bus_to.start = 1'b1;
    @(posedge clk);
    e = 1;
    #1;
    bus_to.start = 1'b0;
    step_to(e, 87);
    chk("to_led_before",  64'(bus_to.led),     64'hFF00);
    chk("to_flag_before", 64'(bus_to.timeout), 64'h0);
    step_to(e, 88);
    chk("to_done",    64'(bus_to.done),    64'h1);
    chk("to_flag",    64'(bus_to.timeout), 64'h1);
    chk("to_led",     64'(bus_to.led),     64'h0);
    chk("to_busy",    64'(bus_to.busy),    64'h0);
    step_to(e, 89);
    chk("to_sticky",  64'(bus_to.timeout), 64'h1);
    chk("to_pulse",   64'(bus_to.done),    64'h0);
    bus_to.start = 1'b1;
    @(posedge clk);
    e = 1;
    #1;
    bus_to.start = 1'b0;
    chk("to_cleared", 64'(bus_to.timeout), 64'h0);
    chk("to_restart", 64'(bus_to.phase),   64'd1);
    bus_to.stop = 1'b1;
    step_to(e, 2);
    bus_to.stop = 1'b0;
  endtask

  task automatic test_prescale();
    int e;
    bus_div.dir   = 1'b0;
    bus_div.start = 1'b1;
    @(posedge clk);
    e = 1;
    #1;
    bus_div.start = 1'b0;
    step_to(e, 4);
    chk("div_no_step", 64'(bus_div.led), 64'h0000);
    step_to(e, 5);
    chk("div_step1",   64'(bus_div.led), 64'h0001);
    step_to(e, 8);
    chk("div_hold",    64'(bus_div.led), 64'h0001);
    step_to(e, 9);
    chk("div_step2",   64'(bus_div.led), 64'h0003);
    step_to(e, 468);
    chk("div_done_early", 64'(bus_div.done), 64'h0);
    step_to(e, 469);
    chk("div_done",     64'(bus_div.done), 64'h1);
    chk("div_led_done", 64'(bus_div.led),  64'h0);
    bus_div.start = 1'b1;
    @(posedge clk);
    e = 1;
    #1;
    bus_div.start = 1'b0;
    step_to(e, 6);
    chk("div_mid_led", 64'(bus_div.led), 64'h0001);
    bus_div.stop = 1'b1;
    step_to(e, 7);
    bus_div.stop = 1'b0;
    chk("div_stop_phase", 64'(bus_div.phase), 64'd0);
    chk("div_stop_led",   64'(bus_div.led),   64'h0);
    chk("div_stop_busy",  64'(bus_div.busy),  64'h0);
  endtask

  task automatic test_wrap();
    int e;
    bus_wrap.dir   = 1'b0;
    bus_wrap.start = 1'b1;
    @(posedge clk);
    e = 1;
    #1;
    bus_wrap.start = 1'b0;
    step_to(e, 11);
    chk("wrap_round1",    64'(bus_wrap.led), 64'h00F);
    step_to(e, 17);
    chk("wrap_r2_fwd",    64'(bus_wrap.led), 64'h3FF);
    step_to(e, 21);
    chk("wrap_round2",    64'(bus_wrap.led), 64'h0FF);
    step_to(e, 22);
    chk("wrap_r3_led8",   64'(bus_wrap.led), 64'h1FF);
    step_to(e, 27);
    chk("wrap_r3_fwd",    64'(bus_wrap.led), 64'h3FF);
    step_to(e, 31);
    chk("wrap_round3",    64'(bus_wrap.led), 64'h3F3);
    chk("wrap_in_toggle", 64'(bus_wrap.phase), 64'd3);
    bus_wrap.stop = 1'b1;
    step_to(e, 32);
    bus_wrap.stop = 1'b0;
    chk("wrap_stopped",   64'(bus_wrap.led), 64'h0);
  endtask

  initial begin
    bus_def.start  = 1'b0; bus_def.stop  = 1'b0; bus_def.dir  = 1'b0;
    bus_div.start  = 1'b0; bus_div.stop  = 1'b0; bus_div.dir  = 1'b0;
    bus_to.start   = 1'b0; bus_to.stop   = 1'b0; bus_to.dir   = 1'b0;
    bus_wrap.start = 1'b0; bus_wrap.stop = 1'b0; bus_wrap.dir = 1'b0;

    test_reset();
    test_fill_toggle();
    test_dir_reverse();
    test_reset_mid_run();
    test_abort();
    test_start_held();
    test_start_stop_idle();
    test_timeout();
    test_prescale();
    test_wrap();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
